// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] IF_NOP              = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] IF_PC_INC           = 32'h0000_0004;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stat_counter.sv
// Wrapping statistics counter: counts enabled cycles, cleared by reset.
module if_stat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_in,
  output logic [CNT_W-1:0] cnt_out
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_in) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register with redirect/stall/halt.
// Define IF_STAT_EN to build the four performance counters; otherwise they read as zero.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             halt_in,
  input  logic             jmp_in,
  input  logic             bsuccess_in,
  input  logic [31:0]      nextpc_in,
  input  logic [31:0]      ir_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      id_pc_out,
  output logic [31:0]      id_ir_out,
  output logic             id_valid_out,
  output logic             flush_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic [CNT_W-1:0] jump_cnt_out,
  output logic [CNT_W-1:0] branch_cnt_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_ir_q, id_ir_d;
  logic        id_valid_q, id_valid_d;
  logic        redirect_s;
  logic        unused_s;

  assign redirect_s = jmp_in | bsuccess_in;
  assign flush_out  = ~halt_in & redirect_s;
  assign unused_s   = ^nextpc_in[1:0];

  // Priority: halt > redirect > stall > advance. A redirect squashes a stalled wrong-path instruction.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_ir_d    = id_ir_q;
    id_valid_d = id_valid_q;
    if (halt_in) begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_ir_d    = id_ir_q;
      id_valid_d = id_valid_q;
    end else if (redirect_s) begin
      pc_d       = pc_align(nextpc_in);
      id_pc_d    = 32'h0000_0000;
      id_ir_d    = IF_NOP;
      id_valid_d = 1'b0;
    end else if (stall_in) begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_ir_d    = id_ir_q;
      id_valid_d = id_valid_q;
    end else begin
      pc_d       = pc_q + IF_PC_INC;
      id_pc_d    = pc_q;
      id_ir_d    = ir_in;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= pc_align(RESET_PC);
      id_pc_q    <= 32'h0000_0000;
      id_ir_q    <= IF_NOP;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_ir_q    <= id_ir_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign pc_out       = pc_q;
  assign id_pc_out    = id_pc_q;
  assign id_ir_out    = id_ir_q;
  assign id_valid_out = id_valid_q;

`ifdef IF_STAT_EN
  logic cycle_en_s, jump_en_s, branch_en_s, stall_en_s;

  assign cycle_en_s  = ~halt_in;
  assign jump_en_s   = ~halt_in & jmp_in;
  assign branch_en_s = ~halt_in & bsuccess_in;
  assign stall_en_s  = ~halt_in & stall_in & ~redirect_s;

  if_stat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .en_in(cycle_en_s), .cnt_out(cycle_cnt_out)
  );
  if_stat_counter #(.CNT_W(CNT_W)) u_jump_cnt (
    .clk(clk), .rst_n(rst_n), .en_in(jump_en_s), .cnt_out(jump_cnt_out)
  );
  if_stat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk(clk), .rst_n(rst_n), .en_in(branch_en_s), .cnt_out(branch_cnt_out)
  );
  if_stat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .en_in(stall_en_s), .cnt_out(stall_cnt_out)
  );
`else
  assign cycle_cnt_out  = {CNT_W{1'b0}};
  assign jump_cnt_out   = {CNT_W{1'b0}};
  assign branch_cnt_out = {CNT_W{1'b0}};
  assign stall_cnt_out  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; counter expectations follow IF_STAT_EN.
module tb_if_fetch_stage;

  localparam logic [31:0] IR_KEY = 32'hC0DE_0000;

  logic        clk;
  logic        rst_n;
  logic        stall_in, halt_in, jmp_in, bsuccess_in;
  logic [31:0] nextpc_in, ir_in;
  logic [31:0] pc_out, id_pc_out, id_ir_out;
  logic        id_valid_out, flush_out;
  logic [31:0] cycle_cnt_out, jump_cnt_out, branch_cnt_out, stall_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_in(stall_in), .halt_in(halt_in), .jmp_in(jmp_in), .bsuccess_in(bsuccess_in),
    .nextpc_in(nextpc_in), .ir_in(ir_in),
    .pc_out(pc_out), .id_pc_out(id_pc_out), .id_ir_out(id_ir_out),
    .id_valid_out(id_valid_out), .flush_out(flush_out),
    .cycle_cnt_out(cycle_cnt_out), .jump_cnt_out(jump_cnt_out),
    .branch_cnt_out(branch_cnt_out), .stall_cnt_out(stall_cnt_out)
  );

  // Instruction memory model: word is a fixed function of the fetch address.
  assign ir_in = pc_out ^ IR_KEY;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef IF_STAT_EN
    return v;
`else
    return 32'h0000_0000 & v;
`endif
  endfunction

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] idpc,
                           input logic [31:0] idir, input logic vld);
    check_eq({tag, ".pc"}, pc_out, pc);
    check_eq({tag, ".id_pc"}, id_pc_out, idpc);
    check_eq({tag, ".id_ir"}, id_ir_out, idir);
    check_eq({tag, ".valid"}, {31'h0, id_valid_out}, {31'h0, vld});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] cyc, input logic [31:0] jmp,
                         input logic [31:0] br, input logic [31:0] st);
    check_eq({tag, ".cycle_cnt"}, cycle_cnt_out, exp_cnt(cyc));
    check_eq({tag, ".jump_cnt"}, jump_cnt_out, exp_cnt(jmp));
    check_eq({tag, ".branch_cnt"}, branch_cnt_out, exp_cnt(br));
    check_eq({tag, ".stall_cnt"}, stall_cnt_out, exp_cnt(st));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; halt_in = 1'b0; jmp_in = 1'b0; bsuccess_in = 1'b0;
    nextpc_in = 32'h0000_0000;
    #12;
    chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    check_eq("reset.flush", {31'h0, flush_out}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("run0.pc", pc_out, 32'h0);
    step();
    chk_state("run1", 32'h4, 32'h0, 32'h0 ^ IR_KEY, 1'b1);
    chk_cnt("run1", 32'd1, 32'd0, 32'd0, 32'd0);
    step();
    chk_state("run2", 32'h8, 32'h4, 32'h4 ^ IR_KEY, 1'b1);

    // Load-use stall for two edges at pc 8.
    stall_in = 1'b1;
    #1 check_eq("stall.flush", {31'h0, flush_out}, 32'h0);
    step();
    chk_state("stall1", 32'h8, 32'h4, 32'h4 ^ IR_KEY, 1'b1);
    step();
    chk_state("stall2", 32'h8, 32'h4, 32'h4 ^ IR_KEY, 1'b1);
    chk_cnt("stall2", 32'd4, 32'd0, 32'd0, 32'd2);
    stall_in = 1'b0;
    step();
    chk_state("run3", 32'hC, 32'h8, 32'h8 ^ IR_KEY, 1'b1);

    // Taken branch with unaligned target.
    bsuccess_in = 1'b1; nextpc_in = 32'h0000_0043;
    #1 check_eq("br.flush", {31'h0, flush_out}, 32'h1);
    step();
    chk_state("br", 32'h40, 32'h0, 32'h0, 1'b0);
    chk_cnt("br", 32'd6, 32'd0, 32'd1, 32'd2);
    bsuccess_in = 1'b0;
    #1 check_eq("br.flush_off", {31'h0, flush_out}, 32'h0);
    step();
    chk_state("br_tgt", 32'h44, 32'h40, 32'h40 ^ IR_KEY, 1'b1);

    // Jump overrides a simultaneous stall; stall not counted.
    jmp_in = 1'b1; stall_in = 1'b1; nextpc_in = 32'h0000_0100;
    #1 check_eq("jstall.flush", {31'h0, flush_out}, 32'h1);
    step();
    chk_state("jstall", 32'h100, 32'h0, 32'h0, 1'b0);
    chk_cnt("jstall", 32'd8, 32'd1, 32'd1, 32'd2);

    // Jump and branch together bump both counters.
    stall_in = 1'b0; bsuccess_in = 1'b1; nextpc_in = 32'h0000_0200;
    step();
    chk_state("jbr", 32'h200, 32'h0, 32'h0, 1'b0);
    chk_cnt("jbr", 32'd9, 32'd2, 32'd2, 32'd2);
    jmp_in = 1'b0; bsuccess_in = 1'b0;
    step();
    chk_state("run4", 32'h204, 32'h200, 32'h200 ^ IR_KEY, 1'b1);

    // Halt for five edges, with a jump request that must be ignored.
    halt_in = 1'b1; jmp_in = 1'b1; nextpc_in = 32'h0000_0300;
    #1 check_eq("halt.flush", {31'h0, flush_out}, 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk_state("halt", 32'h204, 32'h200, 32'h200 ^ IR_KEY, 1'b1);
    chk_cnt("halt", 32'd10, 32'd2, 32'd2, 32'd2);
    halt_in = 1'b0; jmp_in = 1'b0;
    step();
    chk_state("resume", 32'h208, 32'h204, 32'h204 ^ IR_KEY, 1'b1);
    chk_cnt("resume", 32'd11, 32'd2, 32'd2, 32'd2);

    // PC wraps from the top of the address space to zero.
    jmp_in = 1'b1; nextpc_in = 32'hFFFF_FFFC;
    step();
    check_eq("wrap.tgt", pc_out, 32'hFFFF_FFFC);
    jmp_in = 1'b0;
    step();
    chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ IR_KEY, 1'b1);

    // Asynchronous reset mid-stall at pc 0x20.
    jmp_in = 1'b1; nextpc_in = 32'h0000_001C;
    step();
    jmp_in = 1'b0;
    step();
    check_eq("pre_rst.pc", pc_out, 32'h20);
    stall_in = 1'b1;
    step();
    chk_state("pre_rst", 32'h20, 32'h1C, 32'h1C ^ IR_KEY, 1'b1);
    chk_cnt("pre_rst", 32'd16, 32'd4, 32'd2, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("async_rst", 32'd0, 32'd0, 32'd0, 32'd0);
    jmp_in = 1'b1;
    #1 check_eq("rst.flush", {31'h0, flush_out}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
